// File: rtl/data_sram_resp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_sram_resp_pkg : shared encodings and entry-width helpers             |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package data_sram_resp_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

  // {wr, wstrb, word index, wdata, countdown}
  function automatic int req_entry_len(input int aw, input int latency);
    return 1 + STRB_W + aw + DATA_W + cnt_width(latency);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_sram_resp_req_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_sram_resp_req_fifo : in-order request queue, per-entry countdown     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module data_sram_resp_req_fifo #(
  parameter int DEPTH   = 2,
  parameter int PW      = 47,
  parameter int CW      = 1,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_i,
  input  logic [PW-1:0] push_data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          head_ready_o,
  output logic [PW-1:0] head_data_o
);

  localparam int            PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CNTW     = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CW-1:0]   cnt_q [DEPTH];
  logic [CW-1:0]   cnt_d [DEPTH];
  logic [PW-1:0]   data_q [DEPTH];

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d[i] = (valid_q[i] && (cnt_q[i] != '0)) ? cnt_q[i] - CW'(1) : cnt_q[i];
    end
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    // Pushes never target the head slot: push requires not-full, pop requires not-empty
    if (push_i) begin
      valid_d[tail_q] = 1'b1;
      cnt_d[tail_q]   = CNT_INIT;
      tail_d          = ptr_inc(tail_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) data_q[tail_q] <= push_data_i;
  end

  assign full_o       = (count_q == CNTW'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign head_ready_o = valid_q[head_q] && (cnt_q[head_q] == '0);
  assign head_data_o  = data_q[head_q];

endmodule
`default_nettype wire

// File: rtl/data_sram_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_sram_resp : in-order data_sram slave backed by a word-addressed RAM |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        bp
);

  localparam int CW = cnt_width(LATENCY);
  localparam int PW = req_entry_len(AW, LATENCY) - CW;

  logic          w_full, w_empty, w_head_ready, w_push, w_pop;
  logic [PW-1:0] w_push_data, w_head;
  logic          w_head_wr;
  logic [3:0]    w_head_strb;
  logic [AW-1:0] w_head_idx;
  logic [31:0]   w_head_wdata;
  logic          w_size_known, w_unused;

  logic          data_ok_q, data_ok_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [2**AW];

  // Registered count only: a pop on this edge does not open a slot
  assign w_push            = data_sram_req & ~bp & ~w_full;
  assign data_sram_addr_ok = w_push;
  assign w_push_data       = {data_sram_wr, data_sram_wstrb, data_sram_addr[AW+1:2], data_sram_wdata};

  assign w_head_wr    = w_head[PW-1];
  assign w_head_strb  = w_head[PW-2 -: 4];
  assign w_head_idx   = w_head[DATA_W +: AW];
  assign w_head_wdata = w_head[DATA_W-1:0];

  // Gated by resetn so nothing queued retires on the reset edge
  assign w_pop = resetn & ~w_empty & w_head_ready;

  data_sram_resp_req_fifo #(
    .DEPTH   (DEPTH),
    .PW      (PW),
    .CW      (CW),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (w_push),
    .push_data_i  (w_push_data),
    .pop_i        (w_pop),
    .full_o       (w_full),
    .empty_o      (w_empty),
    .head_ready_o (w_head_ready),
    .head_data_o  (w_head)
  );

  always_ff @(posedge clk) begin
    if (w_pop && w_head_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_head_strb[i]) mem_q[w_head_idx][8*i +: 8] <= w_head_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    data_ok_d = w_pop;
    rdata_d   = rdata_q;
    if (w_pop) rdata_d = w_head_wr ? 32'h0 : mem_q[w_head_idx];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = rdata_q;

  // Size, byte offset and high address bits carry no behaviour here
  assign w_size_known = (data_sram_size == SIZE_B) | (data_sram_size == SIZE_H) |
                        (data_sram_size == SIZE_W);
  assign w_unused     = ^{w_size_known, data_sram_addr[31:AW+2], data_sram_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_data_sram_resp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_sram_resp : directed bench over three latency configurations     |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req   [3];
  logic        wr    [3];
  logic        bp    [3];
  logic [1:0]  size  [3];
  logic [3:0]  strb  [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        aok   [3];
  logic        dok   [3];
  logic [31:0] rd    [3];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rq [$];

  always #5 clk = ~clk;

  data_sram_resp #(.AW(10), .DEPTH(2), .LATENCY(2)) u_dut0 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
    .data_sram_size(size[0]), .data_sram_wstrb(strb[0]), .data_sram_addr(addr[0]),
    .data_sram_wdata(wdata[0]), .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]),
    .data_sram_rdata(rd[0]), .bp(bp[0]));

  data_sram_resp #(.AW(10), .DEPTH(2), .LATENCY(4)) u_dut1 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
    .data_sram_size(size[1]), .data_sram_wstrb(strb[1]), .data_sram_addr(addr[1]),
    .data_sram_wdata(wdata[1]), .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]),
    .data_sram_rdata(rd[1]), .bp(bp[1]));

  data_sram_resp #(.AW(10), .DEPTH(2), .LATENCY(1)) u_dut2 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[2]), .data_sram_wr(wr[2]),
    .data_sram_size(size[2]), .data_sram_wstrb(strb[2]), .data_sram_addr(addr[2]),
    .data_sram_wdata(wdata[2]), .data_sram_addr_ok(aok[2]), .data_sram_data_ok(dok[2]),
    .data_sram_rdata(rd[2]), .bp(bp[2]));

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) if (dok[s]) rq.push_back(rd[s]);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic r, input logic w, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    req[s]   = r;
    wr[s]    = w;
    strb[s]  = st;
    addr[s]  = a;
    wdata[s] = d;
    size[s]  = 2'd2;
  endtask

  // Entered and left at edge+1; holds the request until it is accepted
  task automatic issue(input int s, input logic w, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    drive(s, 1'b1, w, st, a, d);
    while (!acc && n < 50) begin
      #1;
      acc = aok[s];
      @(posedge clk);
      #1;
      n++;
    end
    req[s] = 1'b0;
    chk("accept", {31'h0, acc}, 32'h1);
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] exp [$]);
    for (int n = 0; n < 100 && rq.size() < exp.size(); n++) @(posedge clk);
    @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(rq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      chk(tag, (i < rq.size()) ? rq[i] : 32'hxxxxxxxx, exp[i]);
    end
    rq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] eq [$];
    logic [6:0]  aexp, dexp;

    for (int s = 0; s < 3; s++) begin
      drive(s, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      bp[s] = 1'b0;
    end
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_data_ok", {31'h0, dok[s]}, 32'h0);
      chk("rst_rdata", rd[s], 32'h0);
    end
    resetn = 1'b1;

    // Cycle-exact write then read at LATENCY=2
    drive(0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
    #1 chk("wr_addr_ok", {31'h0, aok[0]}, 32'h1);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    #1 chk("rd_addr_ok", {31'h0, aok[0]}, 32'h1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    #1 chk("lat_e1_data_ok", {31'h0, dok[0]}, 32'h0);
    @(posedge clk); #2;
    chk("wr_data_ok", {31'h0, dok[0]}, 32'h1);
    chk("wr_rdata", rd[0], 32'h0);
    @(posedge clk); #2;
    chk("rd_data_ok", {31'h0, dok[0]}, 32'h1);
    chk("rd_rdata", rd[0], 32'hDEADBEEF);
    @(posedge clk); #2;
    chk("idle_data_ok", {31'h0, dok[0]}, 32'h0);
    chk("hold_rdata", rd[0], 32'hDEADBEEF);
    @(posedge clk); #1;
    rq.delete();

    // Byte-lane merges
    issue(0, 1'b1, 4'hF, 32'h200, 32'h11223344);
    issue(0, 1'b1, 4'b0100, 32'h200, 32'hAAAAAAAA);
    issue(0, 1'b0, 4'h0, 32'h200, 32'h0);
    issue(0, 1'b1, 4'b0011, 32'h200, 32'h5555BBCC);
    issue(0, 1'b0, 4'h0, 32'h200, 32'h0);
    eq = '{32'h0, 32'h0, 32'h11AA3344, 32'h0, 32'h11AABBCC};
    expect_resp("lanes", eq);

    // Word index wraps modulo 2^AW
    issue(0, 1'b1, 4'hF, 32'h1000, 32'h12345678);
    issue(0, 1'b0, 4'h0, 32'h0000, 32'h0);
    eq = '{32'h0, 32'h12345678};
    expect_resp("addr_wrap", eq);

    // Five requests cycle the two-entry queue pointers
    issue(0, 1'b1, 4'hF, 32'h300, 32'hA1A1A1A1);
    issue(0, 1'b1, 4'hF, 32'h304, 32'hB2B2B2B2);
    issue(0, 1'b1, 4'hF, 32'h308, 32'hC3C3C3C3);
    issue(0, 1'b0, 4'h0, 32'h308, 32'h0);
    issue(0, 1'b0, 4'h0, 32'h300, 32'h0);
    eq = '{32'h0, 32'h0, 32'h0, 32'hC3C3C3C3, 32'hA1A1A1A1};
    expect_resp("ptr_wrap", eq);

    // Full queue at LATENCY=4: two accepts, stall, third accept after first data_ok
    aexp = 7'b1100011;
    dexp = 7'b1100000;
    drive(1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("full_addr_ok_%0d", k), {31'h0, aok[1]}, {31'h0, aexp[k]});
      chk($sformatf("full_data_ok_%0d", k), {31'h0, dok[1]}, {31'h0, dexp[k]});
      if (k == 6) req[1] = 1'b0;
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("full_nresp", 32'(rq.size()), 32'd3);
    rq.delete();
    bp[1]  = 1'b1;
    req[1] = 1'b1;
    #1 chk("bp_addr_ok", {31'h0, aok[1]}, 32'h0);
    bp[1]  = 1'b0;
    #1 chk("nobp_addr_ok", {31'h0, aok[1]}, 32'h1);
    req[1] = 1'b0;
    @(posedge clk); #1;

    // Reset discards two in-flight reads
    issue(0, 1'b0, 4'h0, 32'h100, 32'h0);
    issue(0, 1'b0, 4'h0, 32'h200, 32'h0);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    #1 chk("post_rst_addr_ok", {31'h0, aok[0]}, 32'h1);
    req[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_nresp", 32'(rq.size()), 32'd0);
    rq.delete();

    // RAM contents survive reset
    issue(0, 1'b0, 4'h0, 32'h0, 32'h0);
    eq = '{32'h12345678};
    expect_resp("persist", eq);

    // LATENCY=1 streaming
    for (int i = 0; i < 8; i++) issue(2, 1'b1, 4'hF, 32'h40 + 32'(4*i), 32'hC0DE0000 + 32'(i));
    eq = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    expect_resp("prefill", eq);
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drive(2, 1'b1, 1'b0, 4'h0, 32'h40 + 32'(4*k), 32'h0);
      else req[2] = 1'b0;
      #1;
      if (k < 8) chk($sformatf("stream_addr_ok_%0d", k), {31'h0, aok[2]}, 32'h1);
      chk($sformatf("stream_data_ok_%0d", k), {31'h0, dok[2]},
          {31'h0, (k >= 2 && k <= 9)});
      @(posedge clk); #1;
    end
    eq = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003,
           32'hC0DE0004, 32'hC0DE0005, 32'hC0DE0006, 32'hC0DE0007};
    expect_resp("stream", eq);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
